// File: rtl/wb_stage.sv
// wb_stage: MIPS write-back stage with CP0 (BadVAddr/Count/Compare/Status/Cause/EPC) and exception/ERET commit.
// Latency: one register stage from ms_to_ws_* to rf_*/flush/stall_ws_bus; those outputs are combinational from the stage register.
// Backpressure: none; ws_allowin is tied high and the stage accepts whatever memory offers every cycle.
// Optional feature macro: CP0_TIMER_INT_EN enables the Count==Compare timer interrupt (Cause.TI onto IP[7]).
module wb_stage #(
   parameter logic [31:0] EXC_ENTRY = 32'hBFC00380
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ms_to_ws_valid,
   input  logic [125:0] ms_to_ws_bus,
   input  logic [5:0]   ext_int_in,
   output logic         ws_allowin,
   output logic [3:0]   rf_we,
   output logic [4:0]   rf_waddr,
   output logic [31:0]  rf_wdata,
   output logic         flush,
   output logic [31:0]  flush_pc,
   output logic [9:0]   stall_ws_bus,
   output logic         ws_int
);

   // Field layout of the memory-to-writeback bus, MSB first.
   typedef struct packed {
      logic [31:0] badvaddr;
      logic        bd;
      logic        exc;
      logic [7:0]  exc_type;
      logic        eret;
      logic        cp0_wen;
      logic        res_from_cp0;
      logic [7:0]  cp0_addr;
      logic [3:0]  gr_we;
      logic [4:0]  dest;
      logic [31:0] result;
      logic [31:0] pc;
   } ws_bus_t;

   // CP0 addresses are {rd[4:0], sel[2:0]}.
   localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
   localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
   localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
   localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
   localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
   localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // Stage register
   logic        ws_valid;
   ws_bus_t     ws_bus;

   // CP0 state, kept as the implemented fields only
   logic [7:0]  st_im;
   logic        st_exl;
   logic        st_ie;
   logic        ca_bd;
   logic        ca_ti;
   logic [5:0]  ca_ip_hw;
   logic [1:0]  ca_ip_sw;
   logic [4:0]  ca_exccode;
   logic [31:0] c0_epc;
   logic [31:0] c0_badvaddr;
   logic [31:0] c0_count;
   logic [31:0] c0_compare;
   logic        count_tick;

   // Commit qualifiers and derived values
   logic        commit_exc;
   logic        commit_mtc0;
   logic        commit_eret;
   logic        wr_count;
   logic        wr_compare;
   logic [4:0]  exc_code;
   logic        exc_is_addr;
   logic [7:0]  cause_ip;
   logic [31:0] status_rd;
   logic [31:0] cause_rd;
   logic [31:0] cp0_rdata;

   assign ws_allowin  = 1'b1;

   // An excepting instruction never writes CP0 or the register file.
   assign commit_exc  = ws_valid & ws_bus.exc;
   assign commit_mtc0 = ws_valid & ws_bus.cp0_wen & ~ws_bus.exc;
   assign commit_eret = ws_valid & ws_bus.eret & ~ws_bus.exc;
   assign wr_count    = commit_mtc0 & (ws_bus.cp0_addr == CP0_COUNT);
   assign wr_compare  = commit_mtc0 & (ws_bus.cp0_addr == CP0_COMPARE);

   // IP[7] carries the timer interrupt alongside hardware line 5.
   assign cause_ip  = {ca_ip_hw[5] | ca_ti, ca_ip_hw[4:0], ca_ip_sw};
   assign status_rd = {9'd0, 1'b1, 6'd0, st_im, 6'd0, st_exl, st_ie};
   assign cause_rd  = {ca_bd, ca_ti, 14'd0, cause_ip, 1'b0, ca_exccode, 2'd0};

   // Stage register: always ready, a flush squashes whatever enters behind it.
   always_ff @(posedge clk) begin
      if (reset) begin
         ws_valid <= 1'b0;
         ws_bus   <= '0;
      end else begin
         ws_valid <= ms_to_ws_valid & ~flush;
         if (ms_to_ws_valid) begin
            ws_bus <= ms_to_ws_bus;
         end
      end
   end

   // Exception code from exc_type, highest-priority cause first.
   always_comb begin
      exc_code    = EXC_INT;
      exc_is_addr = 1'b0;
      if (ws_bus.exc_type[7]) begin
         exc_code = EXC_INT;
      end else if (ws_bus.exc_type[6]) begin
         exc_code    = EXC_ADEL;
         exc_is_addr = 1'b1;
      end else if (ws_bus.exc_type[0]) begin
         exc_code = EXC_RI;
      end else if (ws_bus.exc_type[3]) begin
         exc_code = EXC_OV;
      end else if (ws_bus.exc_type[2]) begin
         exc_code = EXC_SYS;
      end else if (ws_bus.exc_type[1]) begin
         exc_code = EXC_BP;
      end else if (ws_bus.exc_type[5]) begin
         exc_code    = EXC_ADEL;
         exc_is_addr = 1'b1;
      end else if (ws_bus.exc_type[4]) begin
         exc_code    = EXC_ADES;
         exc_is_addr = 1'b1;
      end
   end

   // MFC0 read mux; unimplemented addresses read as zero.
   always_comb begin
      cp0_rdata = 32'd0;
      case (ws_bus.cp0_addr)
         CP0_BADVADDR: cp0_rdata = c0_badvaddr;
         CP0_COUNT:    cp0_rdata = c0_count;
         CP0_COMPARE:  cp0_rdata = c0_compare;
         CP0_STATUS:   cp0_rdata = status_rd;
         CP0_CAUSE:    cp0_rdata = cause_rd;
         CP0_EPC:      cp0_rdata = c0_epc;
         default:      cp0_rdata = 32'd0;
      endcase
   end

   // Status/Cause/EPC/BadVAddr: exception commit, MTC0, ERET and interrupt sampling.
   always_ff @(posedge clk) begin
      if (reset) begin
         st_im       <= 8'd0;
         st_exl      <= 1'b0;
         st_ie       <= 1'b0;
         ca_bd       <= 1'b0;
         ca_ip_hw    <= 6'd0;
         ca_ip_sw    <= 2'd0;
         ca_exccode  <= 5'd0;
         c0_epc      <= 32'd0;
         c0_badvaddr <= 32'd0;
      end else begin
         ca_ip_hw <= ext_int_in;
         if (commit_exc) begin
            st_exl     <= 1'b1;
            ca_exccode <= exc_code;
            // A nested exception keeps the original return point.
            if (!st_exl) begin
               ca_bd  <= ws_bus.bd;
               c0_epc <= ws_bus.bd ? (ws_bus.pc - 32'd4) : ws_bus.pc;
            end
            if (exc_is_addr) begin
               c0_badvaddr <= ws_bus.badvaddr;
            end
         end else if (commit_mtc0) begin
            case (ws_bus.cp0_addr)
               CP0_STATUS: begin
                  st_im  <= ws_bus.result[15:8];
                  st_exl <= ws_bus.result[1];
                  st_ie  <= ws_bus.result[0];
               end
               CP0_CAUSE:    ca_ip_sw    <= ws_bus.result[9:8];
               CP0_EPC:      c0_epc      <= ws_bus.result;
               CP0_BADVADDR: c0_badvaddr <= ws_bus.result;
               default:      ;
            endcase
         end
         if (commit_eret) begin
            st_exl <= 1'b0;
         end
      end
   end

   // Count advances every second cycle; software may overwrite Count and Compare.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_tick <= 1'b0;
         c0_count   <= 32'd0;
         c0_compare <= 32'd0;
      end else begin
         count_tick <= ~count_tick;
         if (wr_count) begin
            c0_count <= ws_bus.result;
         end else if (count_tick) begin
            c0_count <= c0_count + 32'd1;
         end
         if (wr_compare) begin
            c0_compare <= ws_bus.result;
         end
      end
   end

`ifdef CP0_TIMER_INT_EN
   // Timer interrupt: raised when Count reaches Compare, acknowledged by writing Compare.
   always_ff @(posedge clk) begin
      if (reset) begin
         ca_ti <= 1'b0;
      end else if (wr_compare) begin
         ca_ti <= 1'b0;
      end else if (c0_count == c0_compare) begin
         ca_ti <= 1'b1;
      end
   end
`else
   assign ca_ti = 1'b0;
`endif

   assign rf_we        = (ws_valid & ~ws_bus.exc) ? ws_bus.gr_we : 4'd0;
   assign rf_waddr     = ws_bus.dest;
   assign rf_wdata     = ws_bus.res_from_cp0 ? cp0_rdata : ws_bus.result;
   assign flush        = ws_valid & (ws_bus.exc | ws_bus.eret);
   assign flush_pc     = ws_bus.exc ? EXC_ENTRY : c0_epc;
   assign stall_ws_bus = {ws_valid & ws_bus.res_from_cp0, ws_bus.gr_we & {4{ws_valid}}, ws_bus.dest};
   assign ws_int       = st_ie & ~st_exl & (|(cause_ip & st_im));

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage against an instruction-level CP0 model.
// Latency: expected outputs for each cycle are queued by the driver and popped by the monitor on the falling edge.
// Backpressure: none; the DUT is always ready so the driver issues one slot per cycle.
module tb_wb_stage;

   typedef struct packed {
      logic [31:0] badvaddr;
      logic        bd;
      logic        exc;
      logic [7:0]  exc_type;
      logic        eret;
      logic        cp0_wen;
      logic        res_from_cp0;
      logic [7:0]  cp0_addr;
      logic [3:0]  gr_we;
      logic [4:0]  dest;
      logic [31:0] result;
      logic [31:0] pc;
   } instr_t;

   typedef struct packed {
      logic [3:0]  rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
      logic        flush;
      logic [31:0] flush_pc;
      logic [9:0]  stall;
      logic        ws_int;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         ms_to_ws_valid;
   logic [125:0] ms_to_ws_bus;
   logic [5:0]   ext_int_in;
   logic         ws_allowin;
   logic [3:0]   rf_we;
   logic [4:0]   rf_waddr;
   logic [31:0]  rf_wdata;
   logic         flush;
   logic [31:0]  flush_pc;
   logic [9:0]   stall_ws_bus;
   logic         ws_int;

   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];
   logic [5:0] cur_ext = 6'd0;

   // Reference model state: architectural view of the instruction in WB and of CP0.
   logic        m_wv;
   instr_t      m_ins;
   logic [31:0] m_status;   // full register image
   logic [31:0] m_cause;    // BD, IP[9:8], ExcCode; IP[7:2] and TI are merged on read
   logic [5:0]  m_ext;
   logic        m_ti;
   logic [31:0] m_epc, m_bad, m_count, m_compare;
   logic        m_half;

   wb_stage dut (
      .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
      .ext_int_in(ext_int_in), .ws_allowin(ws_allowin), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .flush(flush), .flush_pc(flush_pc), .stall_ws_bus(stall_ws_bus),
      .ws_int(ws_int)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic void model_reset();
      m_wv = 1'b0; m_ins = '0; m_status = 32'h00400000; m_cause = 32'd0; m_ext = 6'd0;
      m_ti = 1'b0; m_epc = 32'd0; m_bad = 32'd0; m_count = 32'd0; m_compare = 32'd0; m_half = 1'b0;
   endfunction

   function automatic logic [31:0] model_cause();
      logic [5:0] hw;
      hw = m_ext;
      if (m_ti) hw[5] = 1'b1;
      return m_cause | (m_ti ? 32'h40000000 : 32'd0) | ({26'd0, hw} << 10);
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] a);
      case (a)
         8'h40:   return m_bad;
         8'h48:   return m_count;
         8'h58:   return m_compare;
         8'h60:   return m_status;
         8'h68:   return model_cause();
         8'h70:   return m_epc;
         default: return 32'd0;
      endcase
   endfunction

   function automatic exp_t model_outputs();
      exp_t e;
      logic [31:0] c;
      logic [7:0] pend;
      c = model_cause();
      pend = c[15:8] & m_status[15:8];
      e.rf_we    = (m_wv && !m_ins.exc) ? m_ins.gr_we : 4'd0;
      e.rf_waddr = m_ins.dest;
      e.rf_wdata = m_ins.res_from_cp0 ? model_read(m_ins.cp0_addr) : m_ins.result;
      e.flush    = m_wv && (m_ins.exc || m_ins.eret);
      e.flush_pc = m_ins.exc ? 32'hBFC00380 : m_epc;
      e.stall    = {m_wv && m_ins.res_from_cp0, m_wv ? m_ins.gr_we : 4'd0, m_ins.dest};
      e.ws_int   = m_status[0] && !m_status[1] && (pend != 8'd0);
      return e;
   endfunction

   // Advance the model by one clock: retire the WB instruction, tick the timer, accept the new one.
   function automatic void model_step(input logic v, input instr_t in, input logic [5:0] ext);
      int order [8] = '{7, 6, 0, 3, 2, 1, 5, 4};
      int codes [8] = '{0, 4, 10, 12, 8, 9, 4, 5};
      logic eq, squash, wr_cnt, wr_cmp;
      int code;
      eq = (m_count == m_compare);
      squash = m_wv && (m_ins.exc || m_ins.eret);
      wr_cnt = 1'b0;
      wr_cmp = 1'b0;
      if (m_wv && m_ins.exc) begin
         code = 0;
         for (int k = 7; k >= 0; k--) if (m_ins.exc_type[order[k]]) code = codes[k];
         if (!m_status[1]) begin
            m_epc = m_ins.bd ? m_ins.pc - 32'd4 : m_ins.pc;
            m_cause[31] = m_ins.bd;
         end
         m_status[1] = 1'b1;
         m_cause[6:2] = code[4:0];
         if (code == 4 || code == 5) m_bad = m_ins.badvaddr;
      end else if (m_wv && m_ins.cp0_wen) begin
         case (m_ins.cp0_addr)
            8'h40: m_bad = m_ins.result;
            8'h48: wr_cnt = 1'b1;
            8'h58: wr_cmp = 1'b1;
            8'h60: m_status = (m_ins.result & 32'h0000FF03) | 32'h00400000;
            8'h68: m_cause[9:8] = m_ins.result[9:8];
            8'h70: m_epc = m_ins.result;
            default: ;
         endcase
      end
      if (m_wv && m_ins.eret && !m_ins.exc) m_status[1] = 1'b0;
`ifdef CP0_TIMER_INT_EN
      if (wr_cmp) m_ti = 1'b0;
      else if (eq) m_ti = 1'b1;
`else
      if (eq) m_ti = 1'b0;
`endif
      if (wr_cnt) m_count = m_ins.result;
      else if (m_half) m_count = m_count + 32'd1;
      m_half = ~m_half;
      if (wr_cmp) m_compare = m_ins.result;
      m_ext = ext;
      m_wv = v && !squash;
      if (v) m_ins = in;
   endfunction

   // One cycle of stimulus: queue this cycle's expected outputs, drive inputs, advance the model.
   task automatic drive(input logic v, input instr_t ins);
      exp_q.push_back(model_outputs());
      ms_to_ws_valid = v;
      ms_to_ws_bus   = ins;
      ext_int_in     = cur_ext;
      model_step(v, ins, cur_ext);
      @(posedge clk);
      #1;
   endtask

   task automatic bubbles(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, instr_t'('0));
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      ms_to_ws_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   function automatic instr_t alu(input logic [4:0] d, input logic [31:0] r);
      instr_t i = '0;
      i.gr_we = 4'hF; i.dest = d; i.result = r; i.pc = 32'h80000040;
      return i;
   endfunction

   function automatic instr_t mfc0(input logic [7:0] a);
      instr_t i = '0;
      i.res_from_cp0 = 1'b1; i.gr_we = 4'hF; i.dest = 5'd9; i.cp0_addr = a;
      return i;
   endfunction

   function automatic instr_t mtc0(input logic [7:0] a, input logic [31:0] r);
      instr_t i = '0;
      i.cp0_wen = 1'b1; i.cp0_addr = a; i.result = r;
      return i;
   endfunction

   function automatic instr_t excp(input logic [7:0] t, input logic [31:0] pc, input logic bd, input logic [31:0] bad);
      instr_t i = '0;
      i.exc = 1'b1; i.exc_type = t; i.pc = pc; i.bd = bd; i.badvaddr = bad; i.gr_we = 4'hF; i.dest = 5'd3;
      return i;
   endfunction

   function automatic instr_t eret_i();
      instr_t i = '0;
      i.eret = 1'b1;
      return i;
   endfunction

   function automatic instr_t rand_instr();
      logic [7:0] addrs [8] = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h61, 8'h00};
      instr_t i = '0;
      int kind = $urandom_range(0, 9);
      i.pc = $urandom & 32'hFFFFFFFC;
      i.dest = 5'($urandom_range(0, 31));
      i.result = $urandom;
      case (kind)
         4: begin i.res_from_cp0 = 1'b1; i.gr_we = 4'hF; i.cp0_addr = addrs[$urandom_range(0, 7)]; end
         5: begin
            i.cp0_wen = 1'b1; i.cp0_addr = addrs[$urandom_range(0, 7)];
            if ($urandom_range(0, 1) == 1) i.result = {16'd0, 8'($urandom), 6'd0, 1'b0, 1'b1};
         end
         6: begin
            i.exc = 1'b1; i.exc_type = 8'($urandom_range(1, 255)); i.bd = 1'($urandom);
            i.badvaddr = $urandom; i.gr_we = 4'($urandom); i.cp0_wen = 1'($urandom);
            i.cp0_addr = addrs[$urandom_range(0, 7)];
         end
         7: i.eret = 1'b1;
         default: i.gr_we = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      endcase
      return i;
   endfunction

   // Monitor: compare every presented cycle against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ws_allowin", {31'd0, ws_allowin}, 32'd1);
            check("rf_we", {28'd0, rf_we}, {28'd0, e.rf_we});
            if (e.rf_we != 4'd0) begin
               check("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.rf_waddr});
               check("rf_wdata", rf_wdata, e.rf_wdata);
            end
            check("flush", {31'd0, flush}, {31'd0, e.flush});
            if (e.flush) check("flush_pc", flush_pc, e.flush_pc);
            check("stall_ws_bus", {22'd0, stall_ws_bus}, {22'd0, e.stall});
            check("ws_int", {31'd0, ws_int}, {31'd0, e.ws_int});
         end
      end
   end

   initial begin
      reset = 1'b1; ms_to_ws_valid = 1'b0; ms_to_ws_bus = '0; ext_int_in = 6'd0;
      do_reset(3);
      bubbles(2);

      // ALU writeback
      drive(1'b1, alu(5'd5, 32'h1234));
      bubbles(1);

      // Data-side AdEL, then read back EPC, Cause, BadVAddr
      drive(1'b1, excp(8'h20, 32'h80001000, 1'b0, 32'h80002001));
      drive(1'b1, alu(5'd7, 32'hDEAD));   // squashed by the flush
      drive(1'b1, mfc0(8'h70));
      drive(1'b1, mfc0(8'h68));
      drive(1'b1, mfc0(8'h40));
      drive(1'b1, eret_i());
      bubbles(1);

      // Syscall in a delay slot, then a nested Bp that must leave EPC/BD alone
      drive(1'b1, excp(8'h04, 32'h80000104, 1'b1, 32'h0));
      bubbles(1);
      drive(1'b1, mfc0(8'h70));
      drive(1'b1, mfc0(8'h68));
      drive(1'b1, excp(8'h02, 32'h80000500, 1'b0, 32'h0));
      bubbles(1);
      drive(1'b1, mfc0(8'h70));
      drive(1'b1, mfc0(8'h68));

      // Interrupt enable with an external line, then ERET to a software EPC
      cur_ext = 6'h01;
      drive(1'b1, mtc0(8'h60, 32'h0000FF01));
      bubbles(3);
      drive(1'b1, mfc0(8'h68));
      drive(1'b1, mtc0(8'h70, 32'h80000200));
      drive(1'b1, eret_i());
      bubbles(1);
      drive(1'b1, mfc0(8'h60));
      cur_ext = 6'h00;
      bubbles(2);

      // Timer: Compare=10 with IM7/IE, then acknowledge by rewriting Compare
      do_reset(2);
      drive(1'b1, mtc0(8'h58, 32'd10));
      drive(1'b1, mtc0(8'h60, 32'h00008001));
      bubbles(24);
      drive(1'b1, mfc0(8'h68));
      drive(1'b1, mfc0(8'h48));
      drive(1'b1, mtc0(8'h58, 32'd1000));
      bubbles(2);
      drive(1'b1, mfc0(8'h68));

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 15) == 0) cur_ext = 6'($urandom);
         drive($urandom_range(0, 4) != 0, rand_instr());
      end

      // Reset while an exception sits in WB: its commit must be discarded
      drive(1'b1, excp(8'h40, 32'h80003000, 1'b1, 32'h12345678));
      do_reset(1);
      cur_ext = 6'h00;
      drive(1'b1, mfc0(8'h70));
      drive(1'b1, mfc0(8'h68));
      drive(1'b1, mfc0(8'h40));
      drive(1'b1, mfc0(8'h60));
      for (int n = 0; n < 300; n++) drive($urandom_range(0, 3) != 0, rand_instr());
      bubbles(1);

      repeat (3) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter EXC_ENTRY, default 32'hBFC00380, exception vector driven on flush_pc for exceptions.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 ms_to_ws_valid  input  1  memory stage holds a valid instruction.
REQ-005 ms_to_ws_bus  input  126  {badvaddr[125:94], bd[93], exc[92], exc_type[91:84], eret[83], cp0_wen[82], res_from_cp0[81], cp0_addr[80:73], gr_we[72:69], dest[68:64], result[63:32], pc[31:0]}.
REQ-006 ext_int_in  input  6  hardware interrupt lines, level-sensitive.
REQ-007 ws_allowin  output  1  stage may accept a new instruction.
REQ-008 rf_we / rf_waddr / rf_wdata  output  4/5/32  register-file byte write enables, index, data.
REQ-009 flush / flush_pc  output  1/32  pipeline flush pulse and redirect target.
REQ-010 stall_ws_bus  output  10  {valid & res_from_cp0, valid-gated gr_we[3:0], dest[4:0]} for ID hazard checks.
REQ-011 ws_int  output  1  pending enabled interrupt, sampled by decode for tagging.

Function
REQ-012 Stage SHALL always be ready: ws_allowin = 1; ws_valid loads ms_to_ws_valid every cycle; flush clears ws_valid on the next edge.
REQ-013 Bus register SHALL capture ms_to_ws_bus only when ms_to_ws_valid is high.
REQ-014 rf_we SHALL be gr_we gated by ws_valid and by ~exc; rf_wdata = CP0 read data when res_from_cp0, else result.
REQ-015 CP0 address SHALL be {rd[4:0], sel[2:0]}; implemented: BadVAddr(8,0), Count(9,0), Compare(11,0), Status(12,0), Cause(13,0), EPC(14,0); other addresses read 0 and ignore writes.
REQ-016 Status SHALL implement IM[15:8], EXL[1], IE[0], bit 22 (BEV) read-only 1, others 0; Cause SHALL implement BD[31], TI[30], IP[15:8], ExcCode[6:2].
REQ-017 MTC0 (valid & cp0_wen & ~exc) SHALL write result to the addressed register in the same edge; only Cause.IP[9:8] are software-writable.
REQ-018 Exception commit (valid & exc) SHALL, in one edge: set EXL, write ExcCode, BD=bd, EPC = bd ? pc-4 : pc (unless EXL already set, then EPC/BD unchanged), BadVAddr=badvaddr for AdEL/AdES.
REQ-019 exc_type priority, bit7 highest: bit7 Int(0), bit6 fetch AdEL(4), bit0 RI(10), bit3 Ov(12), bit2 Sys(8), bit1 Bp(9), bit5 data AdEL(4), bit4 AdES(5).
REQ-020 ERET commit (valid & eret & ~exc) SHALL clear EXL.
REQ-021 flush SHALL be a one-cycle combinational pulse = ws_valid & (exc | eret); flush_pc = EXC_ENTRY on exception, EPC on ERET.
REQ-022 Cause.IP[7:2] SHALL register ext_int_in every cycle; IP[7] also ORed with TI when timer enabled.
REQ-023 ws_int SHALL = IE & ~EXL & |(IP & IM).
REQ-024 Simultaneous exception and MTC0 on the same instruction: exception wins, no CP0 write.
REQ-025 When ERET reads EPC in the same cycle an older MTC0 EPC commits, impossible by pipeline order; stall_ws_bus SHALL hold MFC0 consumers in ID.

Reset
REQ-026 Reset SHALL clear ws_valid, Status to 32'h00400000, Cause to 0, Count to 0; EPC, BadVAddr, Compare undefined-free: reset to 0.
REQ-027 All outputs SHALL be inactive (rf_we=0, flush=0, ws_int=0) in the cycle after reset; reset mid-exception discards the commit.

Configuration
REQ-028 Macro CP0_TIMER_INT_EN: defined -> Count increments every second cycle (internal toggle), Count==Compare sets TI, MTC0 Compare clears TI.
REQ-029 Undefined -> Count still increments, Compare writable, TI constant 0 and never contributes to IP[7].

Verification
REQ-030 Valid ADDU result 32'h1234, dest 5, gr_we 4'hF -> rf_we=F, rf_waddr=5, rf_wdata=32'h1234, no flush.
REQ-031 Data AdEL, pc 32'h80001000, badvaddr 32'h80002001, bd=0 -> flush, flush_pc=BFC00380, EPC=80001000, ExcCode=4, BadVAddr=80002001, rf_we=0.
REQ-032 Syscall in delay slot pc 32'h80000104, bd=1 -> EPC=80000100, Cause.BD=1, ExcCode=8; second exception with EXL=1 leaves EPC unchanged.
REQ-033 MTC0 Status=32'h0000FF01, ext_int_in[0]=1 -> Cause.IP[2]=1 next cycle, ws_int=1; ERET with EPC=80000200 -> flush_pc=80000200, EXL=0.
REQ-034 With CP0_TIMER_INT_EN, Compare=10, IM7=IE=1 -> TI=1 at Count=10, ws_int=1; MTC0 Compare clears TI; without macro ws_int stays 0.
